// File: rtl/empty_ptr_storage_pkg.sv
// Shared hash-table constants: data-table address width and the derived
// number of data-table entries.
package hash_table_pkg;

  localparam int HT_A_WIDTH = 8;
  localparam int HT_N       = 1 << HT_A_WIDTH;

endpackage

// File: rtl/empty_ptr_storage.sv
// Free-address manager for the hash-table data RAM: a circular FIFO of unused
// data-table addresses, filled with every address after reset.
module empty_ptr_storage
  import hash_table_pkg::*;
#(
  parameter int A_WIDTH = HT_A_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  output logic [A_WIDTH-1:0] empty_addr_o,
  output logic               empty_addr_val_o,
  input  logic               empty_addr_rd_ack_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH:0]   empty_cnt_o,
  output logic               init_done_o,
  output logic               err_underflow_o,
  output logic               err_overflow_o
);

  localparam int                 N        = 1 << A_WIDTH;
  localparam logic [A_WIDTH:0]   CNT_FULL = (A_WIDTH+1)'(N);
  localparam logic [A_WIDTH-1:0] PTR_LAST = '1;

  typedef enum logic {
    INIT_S,
    READY_S
  } state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [A_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH:0]     cnt_q, cnt_d;
  logic                 val_q, val_d;
  logic                 init_done_q, init_done_d;
  logic                 underflow_q, underflow_d;
  logic                 overflow_q, overflow_d;

  logic [A_WIDTH-1:0]   mem_q [N];
  logic                 mem_we;
  logic [A_WIDTH-1:0]   mem_waddr;
  logic [A_WIDTH-1:0]   mem_wdata;
  logic                 pop;
  logic                 push;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    mem_wdata   = add_empty_ptr_i;
    pop         = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      INIT_S: begin
        // The fill owns the write port; requests from neighbours are errors here.
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (empty_addr_rd_ack_i) underflow_d = 1'b1;
        if (add_empty_ptr_en_i)  overflow_d  = 1'b1;
        if (init_cnt_q == PTR_LAST) begin
          state_d     = READY_S;
          cnt_d       = CNT_FULL;
          init_done_d = 1'b1;
          rd_ptr_d    = '0;
          wr_ptr_d    = '0;
        end
      end
      READY_S: begin
        // Legality is judged on the pre-cycle count, so a push into an empty
        // list and a pop from a full list both proceed alongside the other side.
        pop  = empty_addr_rd_ack_i && (cnt_q != '0);
        push = add_empty_ptr_en_i && (cnt_q != CNT_FULL);
        if (empty_addr_rd_ack_i && !pop) underflow_d = 1'b1;
        if (add_empty_ptr_en_i && !push) overflow_d  = 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
      default: state_d = INIT_S;
    endcase

    val_d = (cnt_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT_S;
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      val_q       <= 1'b0;
      init_done_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      init_done_q <= init_done_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; the init fill writes every entry before it is read.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign empty_addr_o     = mem_q[rd_ptr_q];
  assign empty_addr_val_o = val_q;
  assign empty_cnt_o      = cnt_q;
  assign init_done_o      = init_done_q;
  assign err_underflow_o  = underflow_q;
  assign err_overflow_o   = overflow_q;

endmodule

// File: tb/tb_empty_ptr_storage.sv
// Self-checking bench for empty_ptr_storage: queue-based free-list model,
// directed boundary cases plus a randomized phase, with a pop scoreboard.
module tb_empty_ptr_storage;

  localparam int AW = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] empty_addr;
  logic          empty_addr_val;
  logic          rd_ack;
  logic [AW-1:0] add_ptr;
  logic          add_en;
  logic [AW:0]   empty_cnt;
  logic          init_done;
  logic          err_underflow;
  logic          err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  int model_q[$];
  int exp_q[$];
  bit uf_m;
  bit of_m;

  always #5 clk = ~clk;

  empty_ptr_storage #(.A_WIDTH(AW)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .empty_addr_o        (empty_addr),
    .empty_addr_val_o    (empty_addr_val),
    .empty_addr_rd_ack_i (rd_ack),
    .add_empty_ptr_i     (add_ptr),
    .add_empty_ptr_en_i  (add_en),
    .empty_cnt_o         (empty_cnt),
    .init_done_o         (init_done),
    .err_underflow_o     (err_underflow),
    .err_overflow_o      (err_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake the DUT completes must match the next expected pop.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_ack === 1'b1 && empty_addr_val === 1'b1) begin
      if (exp_q.size() == 0) check("pop_unexpected", exp_q.size(), 1);
      else                   check("pop_addr", empty_addr, exp_q.pop_front());
    end
  end

  task automatic check_state();
    check("cnt", empty_cnt, model_q.size());
    check("val", empty_addr_val, model_q.size() != 0);
    check("init_done", init_done, 1);
    check("err_underflow", err_underflow, uf_m);
    check("err_overflow", err_overflow, of_m);
    if (model_q.size() != 0) check("head", empty_addr, model_q[0]);
  endtask

  // One clock of stimulus in READY; model applies the free-list rules.
  task automatic cycle(input bit ack, input bit en, input logic [AW-1:0] data);
    int sz;
    rd_ack  = ack;
    add_en  = en;
    add_ptr = data;
    sz = model_q.size();
    if (ack && sz == 0) uf_m = 1'b1;
    if (en && sz == N)  of_m = 1'b1;
    if (ack && sz > 0)  exp_q.push_back(model_q.pop_front());
    if (en && sz < N)   model_q.push_back(int'(data));
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic reset_fill(input bit poke);
    rd_ack  = 1'b0;
    add_en  = 1'b0;
    add_ptr = '0;
    rst_n   = 1'b0;
    model_q.delete();
    exp_q.delete();
    uf_m = 1'b0;
    of_m = 1'b0;
    #1;
    check("rst_val", empty_addr_val, 0);
    check("rst_cnt", empty_cnt, 0);
    check("rst_init_done", init_done, 0);
    check("rst_err_underflow", err_underflow, 0);
    check("rst_err_overflow", err_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= N; i++) begin
      if (poke && i == 3) begin
        rd_ack  = 1'b1;
        add_en  = 1'b1;
        add_ptr = 4'd5;
        uf_m = 1'b1;
        of_m = 1'b1;
      end
      @(posedge clk);
      #1;
      rd_ack = 1'b0;
      add_en = 1'b0;
      if (i < N) begin
        check("init_val_low", empty_addr_val, 0);
        check("init_not_done", init_done, 0);
      end
    end
    for (int a = 0; a < N; a++) model_q.push_back(a);
    check("fill_addr0", empty_addr, 0);
    check_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    rd_ack  = 1'b0;
    add_en  = 1'b0;
    add_ptr = '0;
    #2;
    reset_fill(1'b0);

    // Drain the initial fill, then one extra ack underflows.
    for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);

    // Push into empty list is visible next cycle.
    cycle(1'b0, 1'b1, 4'd7);
    cycle(1'b1, 1'b0, '0);

    // cnt=5, head=3; simultaneous push/pop keeps the count.
    cycle(1'b0, 1'b1, 4'd3);
    for (int v = 10; v <= 13; v++) cycle(1'b0, 1'b1, AW'(v));
    cycle(1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);

    // Empty list: ack underflows while the push is taken.
    cycle(1'b1, 1'b1, 4'd6);
    cycle(1'b1, 1'b0, '0);

    // Fill to capacity, then overflow and pop-with-rejected-push.
    for (int v = 0; v < N; v++) cycle(1'b0, 1'b1, AW'(N - 1 - v));
    cycle(1'b0, 1'b1, 4'd2);
    cycle(1'b1, 1'b1, 4'd5);
    for (int i = 0; i < N - 1; i++) cycle(1'b1, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++)
      cycle(($urandom % 100) < 50, ($urandom % 100) < 50, AW'($urandom));

    // Mid-run reset with four entries held; poke requests during the refill.
    while (model_q.size() > 4) cycle(1'b1, 1'b0, '0);
    while (model_q.size() < 4) cycle(1'b0, 1'b1, AW'($urandom));
    check("pre_reset_cnt", empty_cnt, 4);
    reset_fill(1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, '0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/empty_ptr_storage.md
# empty_ptr_storage

Free-address manager for the hash-table data RAM: keeps every unused data-table address in a circular FIFO and fills it with all 2^A_WIDTH addresses after reset. Sits directly upstream of the insert stage, presenting one free address with a valid flag, and takes the acknowledge when the insert stage commits the address. Also takes addresses back from the delete stage when chain entries are freed.

## Interface
- A_WIDTH, default from hash_table package (8): data-table address width; capacity N = 2^A_WIDTH.
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- empty_addr_o  out  A_WIDTH  current free address (FIFO head), meaningful only when empty_addr_val_o is high.
- empty_addr_val_o  out  1  free address available.
- empty_addr_rd_ack_i  in  1  insert stage consumed empty_addr_o; pop.
- add_empty_ptr_i  in  A_WIDTH  address returned by the delete stage.
- add_empty_ptr_en_i  in  1  push add_empty_ptr_i.
- empty_cnt_o  out  A_WIDTH+1  number of free addresses held.
- init_done_o  out  1  initial fill finished.
- err_underflow_o  out  1  sticky: ack while val low.
- err_overflow_o  out  1  sticky: push while full or during init.

## Operation
- Storage: N-entry register array mem, rd_ptr/wr_ptr (A_WIDTH bits, natural wrap), cnt (A_WIDTH+1 bits, 0..N).
- FSM states INIT_S, READY_S.
- INIT_S: one write per cycle, mem[init_cnt] <= init_cnt, init_cnt from 0 to N-1. After writing N-1 go to READY_S with cnt = N, wr_ptr = 0 (wrapped), rd_ptr = 0. Acks and pushes in INIT_S are ignored; a push sets err_overflow_o, an ack sets err_underflow_o.
- READY_S: stays until reset.
  - empty_addr_o = mem[rd_ptr] (asynchronous read, first-word fall-through); empty_addr_val_o = (cnt != 0).
  - Pop (ack && cnt != 0): rd_ptr++, cnt--.
  - Push (en && cnt != N): mem[wr_ptr] <= add_empty_ptr_i, wr_ptr++, cnt++.
  - Simultaneous pop and push, both legal: both pointers advance, cnt unchanged. When cnt == 0, a simultaneous ack is underflow (ignored, flag set) and the push is accepted.
  - When cnt == N, a simultaneous push is overflow (ignored, flag set) and the pop is accepted.
  - Ack with cnt == 0: no state change, err_underflow_o <= 1.
  - Double-free of an address is not detected; the delete stage guarantees uniqueness.
- Error flags are cleared only by reset.

## Timing
- Reset values: empty_addr_val_o 0, init_done_o 0, empty_cnt_o 0, err_* 0, pointers 0, state INIT_S. empty_addr_o is don't-care (mem is not reset).
- Reset asserted mid-operation: immediately returns to INIT_S. All free-list contents are discarded and the fill restarts after deassertion. The rest of the table is reset on the same rst_n_i.
- Init takes N cycles after the first clock edge following deassertion. empty_addr_val_o and init_done_o rise together on cycle N with empty_addr_o = 0.
- After a pop, the next head appears on empty_addr_o in the following cycle. Back-to-back acks every cycle are supported.
- Push into an empty FIFO: the address is visible with val high one cycle after the en cycle.
- empty_cnt_o is registered and reflects the previous cycle's push/pop.

## Structure
- hash_table package holds A_WIDTH and the derived constant for N (2^A_WIDTH). The block uses the package import like the rest of the table.
- No sub-module needed; storage is an in-block register array, with pointers, count and FSM in the same module.
- State type is a local enum (INIT_S, READY_S).

## Test plan
- Reset then idle, A_WIDTH=4: val low for 16 cycles, then val=1, init_done=1, addr=0, cnt=16.
- 16 consecutive acks after init: addr sequence 0..15, cnt reaches 0, val low. A 17th ack sets err_underflow_o and leaves cnt=0.
- Drained FIFO, push 7: one cycle later val=1, addr=7, cnt=1. Ack: val=0.
- cnt=5 with head=3, push 9 and ack in the same cycle: cnt stays 5, next head is the following entry, and 9 is popped after 4 further acks.
- Full FIFO (cnt=16), push 2: err_overflow_o=1, cnt stays 16, sequence unchanged.
- Assert rst_n_i mid-run with cnt=4: val drops immediately, then the 16-cycle fill repeats and addr=0, cnt=16.
